// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encodings, widths and sequencer state type for the ALU control slice.
package alu_ctrl_pkg;

  localparam int NUM_OPS  = 13;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd12;

  typedef enum logic [2:0] {IDLE, LOADY, EXEC, CAPT, DONE} state_t;

  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    return op < OPCODE_W'(NUM_OPS);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot ALU select, EXEC latency, legality and
// whether the op needs operand A loaded into Y.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 1,
  parameter int CNT_W      = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [NUM_OPS-1:0]  op_sel,
  output logic [CNT_W-1:0]    latency,
  output logic                legal,
  output logic                uses_y
);

  always_comb begin
    legal   = opcode_legal(opcode);
    op_sel  = legal ? (NUM_OPS'(1) << opcode) : '0;
    // NEG and NOT act on B alone, so Y is left untouched.
    uses_y  = !((opcode == OP_NEG) || (opcode == OP_NOT));
    case (opcode)
      OP_DIV:  latency = CNT_W'(DIV_CYCLES);
      OP_MUL:  latency = CNT_W'(MUL_CYCLES);
      default: latency = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: start/ready intake, Y load, timed op_sel, Z capture, done.
// Build option ALU_OPCODE_CHECK_EN: illegal opcodes skip straight to DONE with err.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                ready,
  output logic                y_in,
  output logic                div_clr,
  output logic [NUM_OPS-1:0]  op_sel,
  output logic                z_in,
  output logic                done,
  output logic                err
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t              state, state_n;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_OPS-1:0]  dec_op_sel;
  logic [CNT_W-1:0]    dec_latency;
  logic                dec_legal;
  logic                dec_uses_y;

  alu_op_decode #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_decode (
    .opcode  (op_q),
    .op_sel  (dec_op_sel),
    .latency (dec_latency),
    .legal   (dec_legal),
    .uses_y  (dec_uses_y)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) op_q <= opcode;
      if (state == LOADY)         cnt  <= dec_latency;
      else if (state == EXEC)     cnt  <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    state_n = state;
    ready   = 1'b0;
    y_in    = 1'b0;
    div_clr = 1'b0;
    op_sel  = '0;
    z_in    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
`ifdef ALU_OPCODE_CHECK_EN
          state_n = opcode_legal(opcode) ? LOADY : DONE;
`else
          state_n = LOADY;
`endif
        end
      end
      LOADY: begin
        y_in    = dec_uses_y;
        div_clr = (op_q == OP_DIV);
        state_n = EXEC;
      end
      EXEC: begin
        op_sel = dec_op_sel;
        if (cnt == CNT_W'(1)) state_n = CAPT;
      end
      CAPT: begin
        op_sel  = dec_op_sel;
        z_in    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
`ifdef ALU_OPCODE_CHECK_EN
        err     = !dec_legal;
`endif
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifndef ALU_OPCODE_CHECK_EN
  logic unused_legal;
  assign unused_legal = dec_legal;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected per-op timing,
// a negedge monitor accumulates DUT activity and checks it on each done pulse.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        ready, y_in, div_clr, z_in, done, err;
  logic [12:0] op_sel;

  alu_op_sequencer #(.DIV_CYCLES(32), .MUL_CYCLES(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .ready   (ready),
    .y_in    (y_in),
    .div_clr (div_clr),
    .op_sel  (op_sel),
    .z_in    (z_in),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          t;
    logic [12:0] sel;
    int          sel_cyc;
    int          y;
    int          dc;
    int          z;
    int          lat;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Monitor accumulators, cleared on reset and after each done.
  int          y_cnt, y_t, dc_cnt, dc_t, z_cnt, z_t, sel_cnt, sel_first;
  logic [12:0] sel_or;

  task automatic clear_acc();
    y_cnt = 0; y_t = 0; dc_cnt = 0; dc_t = 0; z_cnt = 0; z_t = 0;
    sel_cnt = 0; sel_first = 0; sel_or = '0;
  endtask

  always @(negedge clk) begin : monitor
    int   obs;
    exp_t e;
    obs = cyc + 1;
    if (reset) begin
      clear_acc();
    end else begin
      if (y_in)    begin y_cnt++;  y_t  = obs; end
      if (div_clr) begin dc_cnt++; dc_t = obs; end
      if (z_in)    begin z_cnt++;  z_t  = obs; end
      if (op_sel != '0) begin
        if (sel_cnt == 0) sel_first = obs;
        sel_cnt++;
        sel_or |= op_sel;
      end
      if (err) check("err_with_done", done, 1);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done_queue", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("done_latency", obs - e.t, e.lat);
          check("err_value", err, e.err);
          check("ready_low_at_done", ready, 0);
          check("y_in_count", y_cnt, e.y);
          if (e.y != 0) check("y_in_time", y_t - e.t, 1);
          check("div_clr_count", dc_cnt, e.dc);
          if (e.dc != 0) check("div_clr_time", dc_t - e.t, 1);
          check("z_in_count", z_cnt, e.z);
          if (e.z != 0) check("z_in_time", obs - z_t, 1);
          check("op_sel_value", sel_or, e.sel);
          check("op_sel_cycles", sel_cnt, e.sel_cyc);
          if (e.sel_cyc != 0) check("op_sel_first", sel_first - e.t, 2);
        end
        clear_acc();
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [12:0] sel, input int sel_cyc,
                       input int y, input int dc, input int z, input int lat,
                       input logic e_err, input bit push, output int t_acc);
    exp_t e;
    int   g;
    g = 0;
    @(negedge clk);
    while (ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("ready_timeout", ready, 1);
    start  = 1'b1;
    opcode = op;
    t_acc  = cyc + 1;
    if (push) begin
      e.t = t_acc; e.sel = sel; e.sel_cyc = sel_cyc; e.y = y; e.dc = dc;
      e.z = z; e.lat = lat; e.err = e_err;
      sb.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    opcode = 4'd9;  // changes after acceptance must not matter
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t, t_mul, t_rol, g;
    clear_acc();
    repeat (3) @(negedge clk);
    check("reset_state", {ready, y_in, div_clr, op_sel, z_in, done, err}, {1'b1, 18'h0});
    reset = 1'b0;

    // ADD, SUB, SHRA: single-cycle EXEC
    issue(4'd0,  13'h0001, 2, 1, 0, 1, 4, 1'b0, 1, t);
    issue(4'd1,  13'h0002, 2, 1, 0, 1, 4, 1'b0, 1, t);
    issue(4'd5,  13'h0020, 2, 1, 0, 1, 4, 1'b0, 1, t);
    // DIV: 32 EXEC cycles plus CAPT, div_clr with Y load
    issue(4'd3,  13'h0008, 33, 1, 1, 1, 35, 1'b0, 1, t);
    // NEG with start pulses while busy
    issue(4'd11, 13'h0800, 2, 0, 0, 1, 4, 1'b0, 1, t);
    start = 1'b1; opcode = 4'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;
    // NOT: unary, no Y load
    issue(4'd12, 13'h1000, 2, 0, 0, 1, 4, 1'b0, 1, t);
    // Back-to-back MUL then ROL
    issue(4'd2,  13'h0004, 2, 1, 0, 1, 4, 1'b0, 1, t_mul);
    issue(4'd8,  13'h0100, 2, 1, 0, 1, 4, 1'b0, 1, t_rol);
    check("back_to_back_gap", t_rol - t_mul, 5);

    // Illegal opcode 14
`ifdef ALU_OPCODE_CHECK_EN
    issue(4'd14, 13'h0000, 0, 0, 0, 0, 1, 1'b1, 1, t);
`else
    issue(4'd14, 13'h0000, 0, 1, 0, 1, 4, 1'b0, 1, t);
`endif

    // DIV aborted by reset at t+10
    issue(4'd3, 13'h0008, 33, 1, 1, 1, 35, 1'b0, 0, t);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_op_sel", op_sel, 13'h0000);
    check("abort_z_done", {z_in, done}, 2'b00);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_activity", y_cnt + dc_cnt + z_cnt + sel_cnt, 0);

    // Normal op after abort
    issue(4'd10, 13'h0400, 2, 1, 0, 1, 4, 1'b0, 1, t);

    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (5) @(negedge clk);
    check("no_trailing_activity", y_cnt + dc_cnt + z_cnt + sel_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
